// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle shared by the arbiter and its environment.
// slave = arbiter side; master = requesters, result consumer and the shared alu32.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_ctrl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_ctrl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_co;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_co;
  logic        alu_overflow;
  logic        alu_zero;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  rsp_ready,
    input  alu_res, alu_co, alu_overflow, alu_zero,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_co, rsp_overflow, rsp_zero,
    output alu_ctrl, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output rsp_ready,
    output alu_res, alu_co, alu_overflow, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_co, rsp_overflow, rsp_zero,
    input  alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared alu32: one operation in flight,
// registered operands toward the ALU, result/flags held until consumed.
module alu_arbiter #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        w_grant;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic [2:0]  r_alu_ctrl;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_rsp_id;
  logic [31:0] r_rsp_res;
  logic        r_rsp_co;
  logic        r_rsp_ov;
  logic        r_rsp_zero;

  // On contention round-robin favours whoever was not served last.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      w_grant = (PRIO_FIXED != 0) ? 1'b0 : ~r_last;
    else if (bus.req1_valid)
      w_grant = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready0 = !rst && bus.req0_valid && !w_grant;
        w_ready1 = !rst && bus.req1_valid &&  w_grant;
        if (w_ready0 || w_ready1) w_state_nxt = EXEC;
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_ready0 | w_ready1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_alu_ctrl <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_res  <= '0;
      r_rsp_co   <= 1'b0;
      r_rsp_ov   <= 1'b0;
      r_rsp_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last     <= w_grant;
        r_alu_ctrl <= w_grant ? bus.req1_ctrl : bus.req0_ctrl;
        r_alu_a    <= w_grant ? bus.req1_a    : bus.req0_a;
        r_alu_b    <= w_grant ? bus.req1_b    : bus.req0_b;
      end
      if (r_state == EXEC) begin
        r_rsp_id   <= r_last;
        r_rsp_res  <= bus.alu_res;
        r_rsp_co   <= bus.alu_co;
        r_rsp_ov   <= bus.alu_overflow;
        r_rsp_zero <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready   = w_ready0;
  assign bus.req1_ready   = w_ready1;
  assign bus.rsp_valid    = (r_state == RESP);
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_res      = r_rsp_res;
  assign bus.rsp_co       = r_rsp_co;
  assign bus.rsp_overflow = r_rsp_ov;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.alu_ctrl     = r_alu_ctrl;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;

endmodule
